// File: rtl/classify_ctrl.sv
// Sequencer for the digit classifier: clears the pipeline, runs each dense layer
// in turn, runs the max-select stage, then holds the captured digit until it is accepted.
module classify_ctrl #(
    parameter int NUM_LAYERS = 2,
    parameter int WIDTH      = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic [NUM_LAYERS-1:0] layer_en,
    output logic                  layer_rst,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic                  sel_en,
    output logic                  sel_rst,
    input  logic                  sel_done,
    input  logic [WIDTH-1:0]      sel_digit,
    output logic [WIDTH-1:0]      digit,
    output logic                  digit_valid,
    input  logic                  digit_ready,
    output logic                  busy,
    output logic                  error
);

    localparam int KW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [KW-1:0] LAST_K   = KW'(NUM_LAYERS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN_LAYER,
        RUN_SEL,
        HOLD,
        ERROR
    } state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic [CW-1:0] cnt;

    // Abort takes priority over every done, timeout and handshake condition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            k     <= '0;
            cnt   <= '0;
            digit <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) state <= CLEAR;
                end
                CLEAR: begin
                    k     <= '0;
                    cnt   <= '0;
                    state <= abort ? IDLE : RUN_LAYER;
                end
                RUN_LAYER: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (layer_done[k]) begin
                        cnt <= '0;
                        if (k == LAST_K) state <= RUN_SEL;
                        else             k     <= k + KW'(1);
                    end else if (cnt == CNT_LAST) begin
                        state <= ERROR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RUN_SEL: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (sel_done) begin
                        digit <= sel_digit;
                        state <= HOLD;
                    end else if (cnt == CNT_LAST) begin
                        state <= ERROR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (abort || digit_ready) state <= IDLE;
                end
                ERROR: begin
                    if (abort) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        layer_en = '0;
        if (state == RUN_LAYER) layer_en[k] = 1'b1;
    end

    assign layer_rst   = (state == CLEAR);
    assign sel_rst     = (state == CLEAR);
    assign sel_en      = (state == RUN_SEL);
    assign digit_valid = (state == HOLD);
    assign busy        = (state != IDLE);
    assign error       = (state == ERROR);

endmodule

// File: tb/tb_classify_ctrl.sv
// Self-checking bench for classify_ctrl: directed runs with a digit scoreboard
// covering normal sequencing, hold handshake, timeout, abort and async reset.
module tb_classify_ctrl;

    localparam int NL = 2;
    localparam int W  = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [NL-1:0] layer_en;
    logic          layer_rst;
    logic [NL-1:0] layer_done;
    logic          sel_en;
    logic          sel_rst;
    logic          sel_done;
    logic [W-1:0]  sel_digit;
    logic [W-1:0]  digit;
    logic          digit_valid;
    logic          digit_ready;
    logic          busy;
    logic          error;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    logic         prev_valid = 1'b0;

    classify_ctrl #(.NUM_LAYERS(NL), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .layer_en(layer_en), .layer_rst(layer_rst), .layer_done(layer_done),
        .sel_en(sel_en), .sel_rst(sel_rst), .sel_done(sel_done),
        .sel_digit(sel_digit), .digit(digit), .digit_valid(digit_valid),
        .digit_ready(digit_ready), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse start for one cycle; a run that should finish queues its digit first.
    task automatic applyStimulus(input bit push_exp, input logic [W-1:0] exp_digit);
        if (push_exp) exp_q.push_back(exp_digit);
        start = 1'b1;
        waitCycles(1);
        start = 1'b0;
    endtask

    task automatic clearInputs();
        start = 0; abort = 0; layer_done = '0; sel_done = 0; sel_digit = '0; digit_ready = 0;
    endtask

    // Scoreboard: every rising digit_valid must match the oldest queued digit.
    always @(negedge clk) begin
        if (digit_valid && !prev_valid) begin
            if (exp_q.size() == 0) checkOutput("sb_unexpected", 1, 0);
            else checkOutput("sb_digit", digit, exp_q.pop_front());
        end
        prev_valid = digit_valid;
    end

    initial begin
        clearInputs();
        reset = 1'b1;
        waitCycles(2);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_valid", digit_valid, 0);
        checkOutput("rst_digit", digit, 0);
        checkOutput("rst_layer_en", layer_en, 0);
        checkOutput("rst_resets", {layer_rst, sel_rst, sel_en}, 0);
        reset = 1'b0;
        waitCycles(1);

        $display("[TB] normal run, digit 7");
        applyStimulus(1, 8'd7);
        checkOutput("clr_layer_rst", layer_rst, 1);
        checkOutput("clr_sel_rst", sel_rst, 1);
        checkOutput("clr_busy", busy, 1);
        checkOutput("clr_layer_en", layer_en, 0);
        waitCycles(1);
        for (int i = 0; i <= 5; i++) begin
            checkOutput("l0_layer_en", layer_en, 2'b01);
            if (i == 2) layer_done[1] = 1'b1;
            if (i == 3) layer_done[1] = 1'b0;
            if (i == 5) layer_done[0] = 1'b1;
            waitCycles(1);
        end
        for (int i = 0; i <= 3; i++) begin
            checkOutput("l1_layer_en", layer_en, 2'b10);
            if (i == 3) layer_done[1] = 1'b1;
            waitCycles(1);
        end
        for (int i = 0; i <= 10; i++) begin
            checkOutput("sel_en", sel_en, 1);
            checkOutput("sel_layer_en", layer_en, 0);
            if (i == 10) begin
                sel_done  = 1'b1;
                sel_digit = 8'd7;
            end
            waitCycles(1);
        end
        for (int i = 0; i < 20; i++) begin
            checkOutput("hold_valid", digit_valid, 1);
            checkOutput("hold_enables", {sel_en, layer_en}, 0);
            start = (i >= 5 && i < 8);
            waitCycles(1);
        end
        checkOutput("hold_digit", digit, 7);
        digit_ready = 1'b1;
        waitCycles(1);
        checkOutput("ack_busy", busy, 0);
        checkOutput("ack_valid", digit_valid, 0);
        checkOutput("ack_digit", digit, 7);
        clearInputs();
        waitCycles(1);
        checkOutput("no_queued_start", busy, 0);

        $display("[TB] zero-wait latency run, digit 5");
        layer_done = 2'b11; sel_done = 1; sel_digit = 8'd5; digit_ready = 1;
        applyStimulus(1, 8'd5);
        waitCycles(1);
        checkOutput("lat_c2_en", layer_en, 2'b01);
        waitCycles(1);
        checkOutput("lat_c3_en", layer_en, 2'b10);
        waitCycles(1);
        checkOutput("lat_c4_valid", digit_valid, 0);
        waitCycles(1);
        checkOutput("lat_c5_valid", digit_valid, 1);
        waitCycles(1);
        checkOutput("lat_c6_busy", busy, 0);
        clearInputs();

        $display("[TB] timeout on layer 1");
        applyStimulus(0, 0);
        waitCycles(1);
        layer_done[0] = 1'b1;
        waitCycles(1);
        for (int i = 0; i < TO; i++) begin
            checkOutput("to_layer_en", layer_en, 2'b10);
            checkOutput("to_error_early", error, 0);
            waitCycles(1);
        end
        checkOutput("to_error", error, 1);
        checkOutput("to_enables", {layer_en, sel_en, layer_rst, sel_rst, digit_valid}, 0);
        checkOutput("to_busy", busy, 1);
        start = 1'b1;
        waitCycles(3);
        start = 1'b0;
        checkOutput("err_ignores_start", error, 1);
        abort = 1'b1;
        waitCycles(1);
        checkOutput("err_abort_error", error, 0);
        checkOutput("err_abort_busy", busy, 0);
        checkOutput("err_abort_digit", digit, 5);
        clearInputs();

        $display("[TB] abort racing sel_done");
        applyStimulus(0, 0);
        waitCycles(1);
        layer_done = 2'b11;
        waitCycles(2);
        checkOutput("ab_sel_en", sel_en, 1);
        sel_done = 1; sel_digit = 8'd3; abort = 1;
        waitCycles(1);
        checkOutput("ab_busy", busy, 0);
        checkOutput("ab_valid", digit_valid, 0);
        checkOutput("ab_digit", digit, 5);
        clearInputs();
        waitCycles(1);

        $display("[TB] async reset mid run");
        applyStimulus(0, 0);
        waitCycles(1);
        checkOutput("ar_pre_en", layer_en, 2'b01);
        #2 reset = 1'b1;
        #1;
        checkOutput("ar_layer_en", layer_en, 0);
        checkOutput("ar_busy", busy, 0);
        checkOutput("ar_digit", digit, 0);
        waitCycles(1);
        reset = 1'b0;
        waitCycles(1);
        applyStimulus(0, 0);
        checkOutput("post_rst_clear", layer_rst, 1);
        abort = 1'b1;
        waitCycles(2);
        checkOutput("post_rst_abort", busy, 0);
        clearInputs();
        waitCycles(2);

        checkOutput("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/classify_ctrl.md
CLASSIFY_CTRL -- requirements
Module: classify_ctrl

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 2, number of dense layers sequenced before the max-select stage (1..8).
REQ-002 SHALL have parameter WIDTH, default 8, width of digit result.
REQ-003 SHALL have parameter TIMEOUT, default 1024, max cycles any stage may run before error (>=2).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request one classification; sampled only in IDLE.
REQ-007 abort  input  1  cancel the run in progress or clear an error.
REQ-008 layer_en  output  NUM_LAYERS  per-layer enable, at most one bit high.
REQ-009 layer_rst  output  1  synchronous clear to all layers.
REQ-010 layer_done  input  NUM_LAYERS  per-layer done flags, level, sticky until layer_rst.
REQ-011 sel_en  output  1  enable to max-select stage.
REQ-012 sel_rst  output  1  synchronous clear to max-select stage.
REQ-013 sel_done  input  1  max-select done, level, sticky.
REQ-014 sel_digit  input  WIDTH  index of max score from max-select stage.
REQ-015 digit  output  WIDTH  captured classification result.
REQ-016 digit_valid  output  1  result available; held until accepted.
REQ-017 digit_ready  input  1  consumer accepts result when high with digit_valid.
REQ-018 busy  output  1  high in any state except IDLE.
REQ-019 error  output  1  high in ERROR state only.

Function
REQ-020 SHALL implement FSM states IDLE, CLEAR, RUN_LAYER, RUN_SEL, HOLD, ERROR, plus layer index k (0..NUM_LAYERS-1) and stage counter cnt.
REQ-021 IDLE: start=1 and abort=0 -> CLEAR next cycle; otherwise stay.
REQ-022 CLEAR: lasts exactly 1 cycle; layer_rst=1, sel_rst=1, k<=0, cnt<=0; -> RUN_LAYER.
REQ-023 RUN_LAYER: layer_en[k]=1, all other bits 0; cnt increments every cycle.
REQ-024 RUN_LAYER with layer_done[k]=1: if k<NUM_LAYERS-1, k<=k+1 and cnt<=0 (stay RUN_LAYER); else -> RUN_SEL, cnt<=0; layer_en[k] high in that cycle, low from next.
REQ-025 layer_done bits other than index k SHALL be ignored.
REQ-026 RUN_SEL: sel_en=1; sel_done=1 -> digit<=sel_digit, -> HOLD.
REQ-027 HOLD: digit_valid=1, all enables 0; digit_ready=1 -> IDLE next cycle, digit retains value.
REQ-028 digit SHALL change only on RUN_SEL->HOLD transition and on reset.
REQ-029 Timeout: in RUN_LAYER or RUN_SEL, cnt==TIMEOUT-1 without the awaited done -> ERROR; done in same cycle wins (normal transition).
REQ-030 ERROR: error=1, all enables and resets 0; leaves only on abort=1 -> IDLE; start ignored.
REQ-031 abort=1 in CLEAR, RUN_LAYER, RUN_SEL, HOLD or ERROR -> IDLE next cycle, overriding done, timeout and digit_ready; digit_valid drops, digit unchanged.
REQ-032 start while busy SHALL be ignored (no queueing).
REQ-033 All outputs SHALL be registered or pure decodes of state/k; no input-to-output combinational path.
REQ-034 Latency: start at cycle 0 -> layer_en[0] high cycle 2; zero-wait stages give digit_valid at cycle 2+NUM_LAYERS+1.

Reset
REQ-035 reset=1 SHALL asynchronously force IDLE, k=0, cnt=0, digit=0, digit_valid=0, busy=0, error=0, layer_en=0, layer_rst=0, sel_en=0, sel_rst=0.
REQ-036 Reset mid-run SHALL discard the run; first post-reset start SHALL run a full CLEAR.

Verification
REQ-037 NUM_LAYERS=2: start pulse, layer_done[0] 5 cycles after en, layer_done[1] 3 cycles after, sel_done 10 cycles after, sel_digit=7 -> digit=7, digit_valid high, layer_en one-hot, correct order.
REQ-038 HOLD with digit_ready low 20 cycles then high -> digit_valid stays 1 for 20 cycles, IDLE next cycle, second start ignored while busy.
REQ-039 TIMEOUT=16, layer_done[1] never asserted -> error=1 exactly 16 cycles after layer_en[1] rises; enables 0; abort -> IDLE, error=0.
REQ-040 layer_done[1] asserted while k=0 -> no effect; advance only on layer_done[0].
REQ-041 abort during RUN_SEL same cycle as sel_done with sel_digit=3 -> IDLE, digit keeps prior value, digit_valid=0.
REQ-042 reset asserted mid RUN_LAYER between clock edges -> outputs at reset values immediately, before next edge.
